calc_key_sequencer: RTL

//  Keypad-driven sequencer for the signed calculator datapath.
//  - Assembles operand1, operator and operand2 from decoded key presses.
//  - Issues one evaluation strobe to the arithmetic unit and waits for the result.
//  - Captures the result, classifies it as shown or error, and drives the display value.
//  - Sits between the key decoder and the arithmetic unit / 7-seg display formatter.

---
 rtl/calc_key_sequencer.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad-driven sequencer for the signed calculator datapath.
// Builds operand1 / operator / operand2 from decoded keys, strobes the arithmetic
// unit once per evaluation, captures its answer and drives the display value.
// Optional feature macro: CALC_CHAIN_EN -- when defined, an operator key pressed
// while a result is shown reloads that result into operand1 and continues.
module calc_key_sequencer #(
    parameter int unsigned MAX_DIGITS  = 6,
    parameter int unsigned RESULT_WAIT = 2,
    parameter logic [31:0] NULL_CODE   = 32'h00CC0000,
    parameter logic [31:0] ERR_CODE    = 32'h00EE0000
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        key_valid_i,
    input  logic [4:0]  key_code_i,
    input  logic [31:0] ans_i,
    output logic [31:0] operand1_o,
    output logic [31:0] operand2_o,
    output logic [2:0]  operator_o,
    output logic        calc_go_o,
    output logic [31:0] disp_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_OP1  = 3'd0,
        ST_OP2  = 3'd1,
        ST_GO   = 3'd2,
        ST_WAIT = 3'd3,
        ST_SHOW = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam logic [2:0] OPR_DIV = 3'd3;
    localparam logic [2:0] OPR_MOD = 3'd4;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int WW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;

`ifdef CALC_CHAIN_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    // Key decode; key_valid low means every class is inactive.
    logic       is_digit, is_op, is_neg, is_eq, is_clr;
    logic [3:0] digit;
    logic [2:0] op_code;

    assign is_digit = key_valid_i && (key_code_i < 5'd10);
    assign is_op    = key_valid_i && (key_code_i >= 5'd10) && (key_code_i <= 5'd14);
    assign is_neg   = key_valid_i && (key_code_i == 5'd15);
    assign is_eq    = key_valid_i && (key_code_i == 5'd16);
    assign is_clr   = key_valid_i && (key_code_i == 5'd17);
    assign digit    = key_code_i[3:0];
    assign op_code  = 3'(key_code_i - 5'd10);

    state_e         state_q, state_d;
    logic [19:0]    op1_mag_q, op1_mag_d, op2_mag_q, op2_mag_d;
    logic           op1_neg_q, op1_neg_d, op2_neg_q, op2_neg_d;
    logic [CW-1:0]  op1_cnt_q, op1_cnt_d, op2_cnt_q, op2_cnt_d;
    logic [2:0]     opr_q, opr_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [31:0]    result_q, result_d;
    logic [31:0]    operand1_q, operand1_d, operand2_q, operand2_d;
    logic [31:0]    disp_q, disp_d;
    logic           calc_go_q, err_q, busy_q;
    logic           op1_from_res;

    // Magnitude of at most MAX_DIGITS-1 digits times ten plus a digit stays below 2^20.
    function automatic logic [19:0] push_digit(input logic [19:0] mag, input logic [3:0] d);
        return mag * 20'd10 + {16'd0, d};
    endfunction

    // Sign-extended two's-complement view of a magnitude/sign pair.
    function automatic logic [31:0] signed_val(input logic neg, input logic [19:0] mag);
        return neg ? (32'd0 - {12'd0, mag}) : {12'd0, mag};
    endfunction

    // Next-state logic: key handling per state, CLR override, then display selection.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        op1_mag_d    = op1_mag_q;
        op1_neg_d    = op1_neg_q;
        op1_cnt_d    = op1_cnt_q;
        op2_mag_d    = op2_mag_q;
        op2_neg_d    = op2_neg_q;
        op2_cnt_d    = op2_cnt_q;
        opr_d        = opr_q;
        wait_d       = wait_q;
        result_d     = result_q;
        op1_from_res = 1'b0;

        case (state_q)
            ST_OP1: begin
                if (is_digit) begin
                    if (op1_cnt_q < CW'(MAX_DIGITS)) begin
                        op1_mag_d = push_digit(op1_mag_q, digit);
                        op1_cnt_d = op1_cnt_q + 1'b1;
                    end
                end else if (is_neg) begin
                    op1_neg_d = ~op1_neg_q;
                end else if (is_op) begin
                    opr_d     = op_code;
                    op2_mag_d = '0;
                    op2_neg_d = 1'b0;
                    op2_cnt_d = '0;
                    state_d   = ST_OP2;
                end
            end
            ST_OP2: begin
                if (is_digit) begin
                    if (op2_cnt_q < CW'(MAX_DIGITS)) begin
                        op2_mag_d = push_digit(op2_mag_q, digit);
                        op2_cnt_d = op2_cnt_q + 1'b1;
                    end
                end else if (is_neg) begin
                    op2_neg_d = ~op2_neg_q;
                end else if (is_op) begin
                    // Operator may still be changed until operand2 has a digit.
                    if (op2_cnt_q == '0) begin
                        opr_d = op_code;
                    end
                end else if (is_eq && (op2_cnt_q != '0)) begin
                    // Division by zero is caught here so the arithmetic unit never sees it.
                    if (((opr_q == OPR_DIV) || (opr_q == OPR_MOD)) && (op2_mag_q == '0)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_GO;
                    end
                end
            end
            ST_GO: begin
                wait_d  = WW'(RESULT_WAIT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    result_d = ans_i;
                    state_d  = ((ans_i == ERR_CODE) || (ans_i == NULL_CODE)) ? ST_ERR : ST_SHOW;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            ST_SHOW: begin
                if (is_digit) begin
                    op1_mag_d = {16'd0, digit};
                    op1_neg_d = 1'b0;
                    op1_cnt_d = CW'(1);
                    op2_mag_d = '0;
                    op2_neg_d = 1'b0;
                    op2_cnt_d = '0;
                    state_d   = ST_OP1;
                end else if (is_op && CHAIN_EN) begin
                    // Chain: the shown result becomes operand1 verbatim.
                    op1_neg_d    = result_q[31];
                    op1_mag_d    = 20'(result_q[31] ? (32'd0 - result_q) : result_q);
                    op1_cnt_d    = '0;
                    op1_from_res = 1'b1;
                    opr_d        = op_code;
                    op2_mag_d    = '0;
                    op2_neg_d    = 1'b0;
                    op2_cnt_d    = '0;
                    state_d      = ST_OP2;
                end
            end
            ST_ERR: begin
                // Only CLR (handled below) leaves ERR.
            end
            default: begin
                state_d = ST_OP1;
            end
        endcase

        // CLR wins in every state; a pending result is simply never captured.
        if (is_clr) begin
            op1_mag_d    = '0;
            op1_neg_d    = 1'b0;
            op1_cnt_d    = '0;
            op2_mag_d    = '0;
            op2_neg_d    = 1'b0;
            op2_cnt_d    = '0;
            opr_d        = '0;
            result_d     = result_q;
            op1_from_res = 1'b0;
            state_d      = ST_OP1;
        end

        operand1_d = op1_from_res ? result_q : signed_val(op1_neg_d, op1_mag_d);
        operand2_d = signed_val(op2_neg_d, op2_mag_d);

        case (state_d)
            ST_OP1:          disp_d = operand1_d;
            ST_OP2:          disp_d = (op2_cnt_d != '0) ? operand2_d : operand1_d;
            ST_GO, ST_WAIT:  disp_d = operand2_d;
            ST_SHOW:         disp_d = result_d;
            ST_ERR:          disp_d = ERR_CODE;
            default:         disp_d = '0;
        endcase
    end

    // State, operand and output registers; every output is registered off the next state.
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OP1;
            op1_mag_q  <= '0;
            op1_neg_q  <= 1'b0;
            op1_cnt_q  <= '0;
            op2_mag_q  <= '0;
            op2_neg_q  <= 1'b0;
            op2_cnt_q  <= '0;
            opr_q      <= '0;
            wait_q     <= '0;
            result_q   <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            disp_q     <= '0;
            calc_go_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state_q    <= state_d;
            op1_mag_q  <= op1_mag_d;
            op1_neg_q  <= op1_neg_d;
            op1_cnt_q  <= op1_cnt_d;
            op2_mag_q  <= op2_mag_d;
            op2_neg_q  <= op2_neg_d;
            op2_cnt_q  <= op2_cnt_d;
            opr_q      <= opr_d;
            wait_q     <= wait_d;
            result_q   <= result_d;
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            disp_q     <= disp_d;
            calc_go_q  <= (state_d == ST_GO);
            err_q      <= (state_d == ST_ERR);
            busy_q     <= (state_d == ST_GO) || (state_d == ST_WAIT);
        end
    end

    assign operand1_o = operand1_q;
    assign operand2_o = operand2_q;
    assign operator_o = opr_q;
    assign calc_go_o  = calc_go_q;
    assign disp_o     = disp_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;
    assign state_o    = state_q;

endmodule
